// File: rtl/result_tx_framer.sv
// ============================================================================
// result_tx_framer: captures result words and serialises them LSB byte first
// into a UART transmitter byte interface, with a one-entry pending buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_tx_framer #(
  parameter int RES_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [RES_WIDTH-1:0] res_data_i,
  input  logic                 res_valid_i,
  input  logic                 tx_busy_i,
  input  logic                 ovr_clr_i,
  output logic [7:0]           tx_p_data_o,
  output logic                 tx_d_vld_o,
  output logic                 frm_busy_o,
  output logic                 overrun_o
);

  localparam int NBYTES = RES_WIDTH / 8;
  localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [RES_WIDTH-1:0] shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [RES_WIDTH-1:0] buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_done;
  logic                 ovr_set;
  logic                 tx_vld;
  logic [7:0]           tx_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    frame_done = 1'b0;
    ovr_set    = 1'b0;
    tx_vld     = 1'b0;
    tx_data    = 8'h00;

    case (state_q)
      IDLE: begin
        if (res_valid_i) begin
          shift_d = res_data_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_data = shift_q[7:0];
        tx_vld  = !tx_busy_i;
        if (!tx_busy_i) state_d = WAIT_HI;
      end
      WAIT_HI: begin
        tx_data = shift_q[7:0];
        if (tx_busy_i) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        tx_data = shift_q[7:0];
        if (!tx_busy_i) begin
          if (cnt_q == LAST_BYTE) begin
            frame_done = 1'b1;
          end else begin
            shift_d = shift_q >> 8;
            cnt_d   = cnt_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // At frame end the buffer drains first, so a coincident result never overruns.
    if (frame_done) begin
      cnt_d = '0;
      if (buf_full_q) begin
        shift_d = buf_q;
        state_d = SEND;
        if (res_valid_i) buf_d = res_data_i;
        else             buf_full_d = 1'b0;
      end else if (res_valid_i) begin
        shift_d = res_data_i;
        state_d = SEND;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q != IDLE && res_valid_i) begin
      if (!buf_full_q) begin
        buf_d      = res_data_i;
        buf_full_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    overrun_d = ovr_set | (overrun_q & ~ovr_clr_i);
  end

  assign tx_p_data_o = tx_data;
  assign tx_d_vld_o  = tx_vld;
  assign frm_busy_o  = (state_q != IDLE) | buf_full_q;
  assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_result_tx_framer.sv
// ============================================================================
// tb_result_tx_framer: directed bench with a 10-cycle-per-byte UART TX model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_tx_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] res_data = 16'h0000;
  logic        res_valid = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        model_busy = 1'b0;
  logic        hold_busy = 1'b0;
  logic        tx_busy;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;
  logic        frm_busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  assign tx_busy = model_busy | hold_busy;

  always #5 clk = ~clk;

  result_tx_framer #(.RES_WIDTH(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .res_data_i  (res_data),
    .res_valid_i (res_valid),
    .tx_busy_i   (tx_busy),
    .ovr_clr_i   (ovr_clr),
    .tx_p_data_o (tx_p_data),
    .tx_d_vld_o  (tx_d_vld),
    .frm_busy_o  (frm_busy),
    .overrun_o   (overrun)
  );

  // UART TX model: a strobe seen before an edge makes it busy for 10 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_d_vld) begin
        got_q.push_back(tx_p_data);
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] d);
    @(posedge clk);
    #1 res_valid = 1'b1;
    res_data = d;
    @(posedge clk);
    #1 res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (frm_busy && n < 600) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, {31'd0, frm_busy}, 32'd0);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (tx_busy !== lvl && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(tag, {31'd0, tx_busy}, {31'd0, lvl});
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_data", {24'd0, tx_p_data}, 32'h0);
    chk("rst_vld", {31'd0, tx_d_vld}, 32'h0);
    chk("rst_busy", {31'd0, frm_busy}, 32'h0);
    chk("rst_ovr", {31'd0, overrun}, 32'h0);

    // 1: single result, first strobe one cycle after pulse
    pulse(16'hA55A);
    chk("t1_first_vld", {31'd0, tx_d_vld}, 32'h1);
    chk("t1_first_data", {24'd0, tx_p_data}, 32'h5A);
    wait_idle("t1_idle");
    chk("t1_busy_low_at_idle", {31'd0, tx_busy}, 32'h0);
    chk("t1_idle_data", {24'd0, tx_p_data}, 32'h0);
    exp_q = '{8'h5A, 8'hA5};
    chk_bytes("t1");

    // 2: second result buffered while first frame is in flight
    pulse(16'h1234);
    repeat (2) @(posedge clk);
    pulse(16'hBEEF);
    chk("t2_busy", {31'd0, frm_busy}, 32'h1);
    wait_idle("t2_idle");
    chk("t2_ovr", {31'd0, overrun}, 32'h0);
    exp_q = '{8'h34, 8'h12, 8'hEF, 8'hBE};
    chk_bytes("t2");

    // 3: three back-to-back results, third dropped
    @(posedge clk);
    #1 res_valid = 1'b1; res_data = 16'h1234;
    @(posedge clk);
    #1 res_data = 16'h5678;
    @(posedge clk);
    #1 res_data = 16'h9ABC;
    @(posedge clk);
    #1 res_valid = 1'b0;
    chk("t3_ovr_set", {31'd0, overrun}, 32'h1);
    wait_idle("t3_idle");
    chk("t3_ovr_sticky", {31'd0, overrun}, 32'h1);
    exp_q = '{8'h34, 8'h12, 8'h78, 8'h56};
    chk_bytes("t3");
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    chk("t3_ovr_clr", {31'd0, overrun}, 32'h0);

    // 4: TX held busy while in SEND, then released
    #0 hold_busy = 1'b1;
    pulse(16'h7788);
    repeat (50) @(posedge clk);
    #1;
    chk("t4_no_strobe", got_q.size(), 32'd0);
    chk("t4_still_busy", {31'd0, frm_busy}, 32'h1);
    hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_one_strobe", got_q.size(), 32'd1);
    wait_idle("t4_idle");
    exp_q = '{8'h88, 8'h77};
    chk_bytes("t4");

    // 5: reset mid-frame with buffer full and overrun set
    pulse(16'hCAFE);
    pulse(16'h1357);
    pulse(16'h2468);
    chk("t5_ovr_before", {31'd0, overrun}, 32'h1);
    chk("t5_one_byte_before", got_q.size(), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_rst_vld", {31'd0, tx_d_vld}, 32'h0);
    chk("t5_rst_busy", {31'd0, frm_busy}, 32'h0);
    chk("t5_rst_ovr", {31'd0, overrun}, 32'h0);
    wait_busy(1'b0, "t5_uart_drain");
    got_q.delete();
    pulse(16'h0001);
    wait_idle("t5_idle");
    exp_q = '{8'h01, 8'h00};
    chk_bytes("t5");

    // 6: new result coincides with final TX_BUSY fall while buffer is full
    pulse(16'h1122);
    pulse(16'h3344);
    begin
      int n = 0;
      while (got_q.size() < 2 && n < 200) begin
        @(posedge clk);
        #2;
        n++;
      end
    end
    chk("t6_two_bytes", got_q.size(), 32'd2);
    wait_busy(1'b1, "t6_busy_rise");
    wait_busy(1'b0, "t6_busy_fall");
    res_valid = 1'b1;
    res_data = 16'h5566;
    @(posedge clk);
    #1 res_valid = 1'b0;
    chk("t6_no_ovr", {31'd0, overrun}, 32'h0);
    wait_idle("t6_idle");
    chk("t6_ovr_end", {31'd0, overrun}, 32'h0);
    exp_q = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55};
    chk_bytes("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
